// File: rtl/core_dispatch_ctrl.sv
// Core dispatch controller: holds one task descriptor until its fence and collision
// rules allow, then broadcasts a mask beat and the task's message beats on the core bus.
module core_dispatch_ctrl #(
  parameter int CORE_NUM    = 16,
  parameter int BUS_TO_CORE = 16,
  parameter int BEAT_CNT_W  = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   task_valid,
  output logic                   task_ready,
  input  logic [CORE_NUM-1:0]    task_mask,
  input  logic [1:0]             task_fence,
  input  logic [BEAT_CNT_W-1:0]  task_beats,
  input  logic [BUS_TO_CORE-1:0] msg_in,
  input  logic                   msg_in_valid,
  output logic                   msg_in_ready,
  output logic [BUS_TO_CORE-1:0] mess_to_core,
  output logic                   mask_strobe,
  output logic                   msg_strobe,
  output logic [CORE_NUM-1:0]    core_sel,
  input  logic [CORE_NUM-1:0]    core_done,
  output logic [CORE_NUM-1:0]    core_busy,
  output logic                   err_empty_mask,
  output logic [STALL_CNT_W-1:0] wait_cycles
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_MASK   = 3'd2,
    ST_STREAM = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  localparam logic [CORE_NUM-1:0]    NO_CORES = {CORE_NUM{1'b0}};
  localparam logic [STALL_CNT_W-1:0] WAIT_MAX = {STALL_CNT_W{1'b1}};

  state_t                  state_r;
  state_t                  state_s;
  logic [CORE_NUM-1:0]     mask_r;
  logic [1:0]              fence_r;
  logic [BEAT_CNT_W-1:0]   beats_r;
  logic [BEAT_CNT_W-1:0]   beat_cnt_r;
  logic                    accept_s;
  logic                    empty_s;
  logic                    dispatch_ok_s;
  logic                    cores_idle_s;
  logic                    beat_acc_s;
  logic                    last_beat_s;

  // Handshake decode, dispatch/release conditions and next-state selection
  always_comb begin
    accept_s      = (state_r == ST_IDLE) && task_valid && task_ready;
    empty_s       = (task_mask == NO_CORES);
    cores_idle_s  = ((core_busy & mask_r) == NO_CORES);
    dispatch_ok_s = 1'b0;
    if (fence_r[0]) begin
      dispatch_ok_s = (core_busy == NO_CORES);
    end else begin
      dispatch_ok_s = cores_idle_s;
    end
    beat_acc_s  = (state_r == ST_STREAM) && msg_in_valid && msg_in_ready;
    last_beat_s = beat_acc_s &&
                  (({1'b0, beat_cnt_r} + {{BEAT_CNT_W{1'b0}}, 1'b1}) == {1'b0, beats_r});
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !empty_s) state_s = ST_WAIT;
        else                      state_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (dispatch_ok_s) state_s = ST_MASK;
        else               state_s = ST_WAIT;
      end
      ST_MASK: begin
        if (beats_r != {BEAT_CNT_W{1'b0}}) state_s = ST_STREAM;
        else if (fence_r[1])               state_s = ST_HOLD;
        else                               state_s = ST_IDLE;
      end
      ST_STREAM: begin
        if (last_beat_s) state_s = fence_r[1] ? ST_HOLD : ST_IDLE;
        else             state_s = ST_STREAM;
      end
      ST_HOLD: begin
        if (cores_idle_s) state_s = ST_IDLE;
        else              state_s = ST_HOLD;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Latched descriptor, beat counter, busy tracking and stall statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_r      <= NO_CORES;
      fence_r     <= 2'b00;
      beats_r     <= {BEAT_CNT_W{1'b0}};
      beat_cnt_r  <= {BEAT_CNT_W{1'b0}};
      core_busy   <= NO_CORES;
      wait_cycles <= {STALL_CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        mask_r  <= task_mask;
        fence_r <= task_fence;
        beats_r <= task_beats;
      end
      if (state_r == ST_MASK)  beat_cnt_r <= {BEAT_CNT_W{1'b0}};
      else if (beat_acc_s)     beat_cnt_r <= beat_cnt_r + {{(BEAT_CNT_W-1){1'b0}}, 1'b1};
      // a dispatch set overrides a same-cycle done for that core
      core_busy <= (core_busy & ~core_done) | ((state_r == ST_MASK) ? mask_r : NO_CORES);
      if ((state_r == ST_WAIT) && !dispatch_ok_s && (wait_cycles != WAIT_MAX))
        wait_cycles <= wait_cycles + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Registered bus and handshake outputs, derived from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      task_ready     <= 1'b1;
      msg_in_ready   <= 1'b0;
      mess_to_core   <= {BUS_TO_CORE{1'b0}};
      mask_strobe    <= 1'b0;
      msg_strobe     <= 1'b0;
      core_sel       <= NO_CORES;
      err_empty_mask <= 1'b0;
    end else begin
      task_ready     <= (state_s == ST_IDLE);
      msg_in_ready   <= (state_s == ST_STREAM);
      mask_strobe    <= (state_s == ST_MASK);
      msg_strobe     <= beat_acc_s;
      err_empty_mask <= accept_s && empty_s;
      if (state_s == ST_MASK) begin
        mess_to_core <= BUS_TO_CORE'(mask_r);
        core_sel     <= mask_r;
      end else if (beat_acc_s) begin
        mess_to_core <= msg_in;
        core_sel     <= mask_r;
      end else begin
        mess_to_core <= {BUS_TO_CORE{1'b0}};
        core_sel     <= NO_CORES;
      end
    end
  end

endmodule

// File: doc/core_dispatch_ctrl.md
Name: core_dispatch_ctrl

Overview:
- Sits between the frame scheduler and the core array.
- Accepts one task descriptor at a time: core mask, fence, beat count. Holds it until the fence and collision rules allow dispatch.
- Then broadcasts a mask beat followed by the task's message beats on the shared 16-bit core bus.
- Tracks per-core busy state from dispatch until each core's done pulse.

Parameters:
- CORE_NUM, 16, number of cores; width of every mask.
- BUS_TO_CORE, 16, core bus width; must be ≥ CORE_NUM.
- BEAT_CNT_W, 8, width of the task beat count.
- STALL_CNT_W, 16, width of the wait-cycle statistics counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- task_valid  in  1  descriptor valid
- task_ready  out  1  descriptor accepted when valid&ready
- task_mask  in  CORE_NUM  target cores
- task_fence  in  2  0=none, 1=acquire, 2=release, 3=acquire+release
- task_beats  in  BEAT_CNT_W  message beats following the mask beat (0 allowed)
- msg_in  in  BUS_TO_CORE  message beat from scheduler
- msg_in_valid  in  1  beat valid
- msg_in_ready  out  1  beat accepted when valid&ready
- mess_to_core  out  BUS_TO_CORE  core bus data
- mask_strobe  out  1  mess_to_core carries a core mask
- msg_strobe  out  1  mess_to_core carries a message beat
- core_sel  out  CORE_NUM  per-core load enable, valid with either strobe
- core_done  in  CORE_NUM  per-core completion pulse
- core_busy  out  CORE_NUM  registered busy vector
- err_empty_mask  out  1  one-cycle pulse: zero-mask task discarded
- wait_cycles  out  STALL_CNT_W  saturating count of cycles spent in WAIT

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs 0 except task_ready=1. Busy, counters and latched descriptor cleared. Reset mid-task abandons the task; no further strobes are issued.
- All outputs are registered. task_ready=1 only in IDLE. msg_in_ready=1 only in STREAM.
- FSM states: IDLE, WAIT, MASK, STREAM, HOLD.
- IDLE: on task_valid, latch mask/fence/beats.
  - task_mask==0: pulse err_empty_mask next cycle and stay in IDLE.
  - Otherwise go to WAIT.
- WAIT: dispatch condition is evaluated on registered core_busy.
  - Fence bit0 (acquire): core_busy==0.
  - Otherwise: (core_busy & mask)==0.
  - When true, go to MASK. While false, wait_cycles increments and saturates at all-ones.
- MASK (exactly 1 cycle): mess_to_core = zero-extended mask, mask_strobe=1, core_sel=mask. core_busy |= mask at end of the cycle.
  - Next state: STREAM if beats≠0.
  - Else HOLD if fence bit1 (release).
  - Else IDLE.
- Minimum latency from task handshake to mask beat: 2 cycles.
- STREAM: a beat accepted at cycle t appears at t+1 as mess_to_core=msg_in, msg_strobe=1, core_sel=mask. No bubbles when msg_in_valid is held high.
  - A beat counter counts accepted beats.
  - On acceptance of beat number `beats`, go to HOLD if release, else IDLE. The final output beat is still emitted in that next cycle.
  - Strobes are 0 in cycles with no accepted beat.
- HOLD: stay until (core_busy & mask)==0, then go to IDLE. task_ready is low throughout HOLD.
- core_done handling:
  - Clears the matching core_busy bit in the following cycle.
  - A done for a non-busy core is ignored.
  - Set and clear of the same bit in the same cycle: set wins. Other bits clear normally.
- Counter arithmetic: the beat counter is BEAT_CNT_W bits, so task_beats=255 is legal with no wrap. wait_cycles clears only on reset.

Test Plan:
- Reset, then task mask=0x0003, fence=0, beats=2, msgs 0xAAAA/0x5555, no busy cores -> mask beat 0x0003 two cycles after the handshake, then 0xAAAA, 0x5555 with core_sel=0x0003. core_busy=0x0003. task_ready back high afterwards.
- core_busy=0x0001; task mask=0x0001 fence=0 -> held in WAIT. Pulse core_done[0] at cycle 10 -> mask beat follows within 2 cycles. wait_cycles equals the stall length.
- core_busy=0x0100; task mask=0x0002 fence=1 -> waits until core 8 is done. Same task with fence=0 -> dispatches immediately.
- Task mask=0x00F0 fence=2 beats=0 -> mask beat only. task_ready stays low until all of cores 4..7 pulse done.
- Task mask=0 -> err_empty_mask high for 1 cycle, no strobes, task_ready stays 1.
- Reset asserted mid-STREAM after 1 of 4 beats -> next cycle: IDLE, strobes 0, core_busy=0. msg_in_ready=0. Also check: core_done[1] in the same cycle as a mask beat for 0x0002 -> core_busy[1]=1.
